io_switch_led_port: RTL and testbench
=====================================

Name: io_switch_led_port

Overview:
- Memory-mapped I/O responder for the minisys-32 CPU; the device end of the MemOrIO ioRead/ioWrite path.
- Owns the board LED output register, the 16 board switch inputs (synchronised, optionally debounced) and a sticky switch-changed status flag.
- Sits beside Data_mem at the CPU top. CPU drives io_read/io_write/addr/wdata; block returns registered rdata with rdata_valid.

Parameters:
- IO_BASE, 32'hFFFFFC00, base of the I/O region; register offsets are added to this.
- DEBOUNCE_CYCLES, 10000, consecutive stable cycles required to commit a switch change; used only with IO_DEBOUNCE_EN; must be >= 1.

Ports:
- clock  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- io_read  input  1  CPU I/O read strobe, one cycle per access.
- io_write  input  1  CPU I/O write strobe, one cycle per access.
- addr  input  32  byte address from the ALU result.
- wdata  input  32  write data; only [15:0] is used.
- rdata  output  32  read data, registered.
- rdata_valid  output  1  high for exactly one cycle when rdata holds a read response.
- switches  input  16  raw board switches, asynchronous to clock.
- leds  output  16  LED register.

Behaviour:
- Register map, decoded by full 32-bit compare:
  - LED at IO_BASE+0x60: read/write; [15:0] = leds, upper bits read 0.
  - SW at IO_BASE+0x70: read-only; [15:0] = committed switch value.
  - STATUS at IO_BASE+0x74: read-only, clear-on-read; bit0 = chg flag.
  - All other addresses are unmapped: writes are ignored; reads return 0 with rdata_valid.
- Reset: leds=0, rdata=0, rdata_valid=0, both sync flops=0, committed switch value=0, candidate=0, debounce counter=0, chg=0.
- Write: with io_write=1 at edge N, leds=wdata[15:0] is visible after edge N. Writes to SW or STATUS are ignored.
- Read: with io_read=1 at edge N, rdata and rdata_valid=1 are visible after edge N, so the data is available in cycle N+1. rdata_valid falls after the next edge unless another read occurs. rdata holds its last value when not reading.
- Back-to-back reads are supported: one response per cycle, with no bubbles.
- io_read and io_write asserted in the same cycle: the write is performed, the read is dropped, and rdata_valid=0 for that response slot.
- Switch path: a 2-flop synchroniser sync[1:0]. The committed value (without IO_DEBOUNCE_EN) is the output of the second flop.
- chg flag:
  - Set on any cycle where the committed value changes.
  - Cleared by a STATUS read, which returns the pre-clear value.
  - If a set and a clear occur in the same cycle, the set wins: chg stays 1 and the read returns the old value.
- Reset asserted mid-operation overrides all activity in that cycle: a pending read produces no valid, and a write is lost.

Optional Feature:
- Macro IO_DEBOUNCE_EN.
- When defined:
  - Debounce FSM with states STABLE and COUNTING; counter width $clog2(DEBOUNCE_CYCLES+1).
  - STABLE: if synced != committed, set candidate=synced, counter=1 and go to COUNTING.
  - COUNTING:
    - If synced != candidate, set candidate=synced and counter=1. If synced == committed, return to STABLE with no commit.
    - Otherwise increment the counter. When counter reaches DEBOUNCE_CYCLES, set committed=candidate, go to STABLE, and set chg.
  - Total latency from a raw edge to commit is 2 + DEBOUNCE_CYCLES cycles.
- When undefined: committed value = synchroniser output, with latency 2 cycles. No counter or FSM logic is generated.

Test Plan:
- Reset, then read LED, SW and STATUS -> each returns 0 one cycle later with rdata_valid pulsing exactly once per read.
- Write 0x0000A5A5 to 0xFFFFFC60 -> leds=16'hA5A5 the next cycle. Read back 0xFFFFFC60 -> rdata=0x0000A5A5. Write to 0xFFFFFC70 -> leds unchanged.
- IO_DEBOUNCE_EN, DEBOUNCE_CYCLES=4:
  - Set switches=16'h0003 -> SW reads 0 until cycle 6 after the edge, then 0x00000003. STATUS returns 1, then 0 on the following read.
  - A glitch on switches (1-cycle pulse) -> SW stays unchanged and chg=0.
- Without IO_DEBOUNCE_EN: switches changes -> SW updates after 2 cycles.
- io_read+io_write same cycle on LED with wdata=0x1234 -> leds=0x1234 and rdata_valid=0. Read of unmapped 0xFFFFFC80 -> rdata=0 with valid=1.
- Switch change commits in the same cycle as a STATUS read -> read returns 0 and chg=1 afterwards. Assert reset mid back-to-back reads -> rdata_valid=0 and leds=0 the next cycle.

Source files
------------

// File: rtl/io_switch_led_port.sv
`default_nettype none
// ============================================================================
// io_switch_led_port : minisys-32 MMIO responder (LED register, switches, chg)
// Optional macro IO_DEBOUNCE_EN adds a switch debounce FSM.   Rev 1.0
// ============================================================================
module io_switch_led_port #(
  parameter logic [31:0] IO_BASE         = 32'hFFFFFC00,
  parameter int unsigned DEBOUNCE_CYCLES = 10000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_read,
  input  logic        io_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  input  logic [15:0] switches,
  output logic [15:0] leds
);

  localparam logic [31:0] c_LED_ADDR    = IO_BASE + 32'h60;
  localparam logic [31:0] c_SW_ADDR     = IO_BASE + 32'h70;
  localparam logic [31:0] c_STATUS_ADDR = IO_BASE + 32'h74;

  logic [15:0] leds_q;
  logic [15:0] sync0_q;
  logic [15:0] sync1_q;
  logic        chg_q;
  logic        chg_d;
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;
  logic        rdata_valid_q;
  logic        w_rd;
  logic        w_sw_set;
  logic [15:0] w_sw_commit;
  logic        w_unused_bits;

  assign w_unused_bits = ^wdata[31:16];

  // A simultaneous write wins; the read slot produces no response.
  assign w_rd = io_read & ~io_write;

  always_comb begin
    rdata_d = 32'h0;
    case (addr)
      c_LED_ADDR:    rdata_d = {16'h0, leds_q};
      c_SW_ADDR:     rdata_d = {16'h0, w_sw_commit};
      c_STATUS_ADDR: rdata_d = {31'h0, chg_q};
      default:       rdata_d = 32'h0;
    endcase
  end

  // Set has priority over the clear-on-read.
  assign chg_d = w_sw_set | (chg_q & ~(w_rd && (addr == c_STATUS_ADDR)));

  always_ff @(posedge clock) begin
    if (reset) begin
      leds_q        <= 16'h0;
      sync0_q       <= 16'h0;
      sync1_q       <= 16'h0;
      chg_q         <= 1'b0;
      rdata_q       <= 32'h0;
      rdata_valid_q <= 1'b0;
    end else begin
      sync0_q       <= switches;
      sync1_q       <= sync0_q;
      chg_q         <= chg_d;
      rdata_valid_q <= w_rd;
      if (io_write && (addr == c_LED_ADDR)) leds_q <= wdata[15:0];
      if (w_rd) rdata_q <= rdata_d;
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam int unsigned c_CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CW-1:0] c_ONE     = c_CW'(1);
  localparam logic [c_CW-1:0] c_LAST_M1 = c_CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } db_state_t;

  db_state_t   state_q;
  logic [15:0] cand_q;
  logic [15:0] committed_q;
  logic [c_CW-1:0] cnt_q;

  // Commit fires on the cycle whose increment would reach DEBOUNCE_CYCLES.
  always_comb begin
    w_sw_set = 1'b0;
    if (state_q == ST_STABLE)
      w_sw_set = (DEBOUNCE_CYCLES == 1) && (sync1_q != committed_q);
    else
      w_sw_set = (sync1_q == cand_q) && (cnt_q >= c_LAST_M1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_STABLE;
      cand_q      <= 16'h0;
      committed_q <= 16'h0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        ST_STABLE: begin
          if (sync1_q != committed_q) begin
            cand_q <= sync1_q;
            cnt_q  <= c_ONE;
            if (w_sw_set) committed_q <= sync1_q;
            else          state_q     <= ST_COUNTING;
          end
        end
        ST_COUNTING: begin
          if (sync1_q != cand_q) begin
            cand_q <= sync1_q;
            cnt_q  <= c_ONE;
            if (sync1_q == committed_q) state_q <= ST_STABLE;
          end else if (w_sw_set) begin
            committed_q <= cand_q;
            state_q     <= ST_STABLE;
          end else begin
            cnt_q <= cnt_q + c_ONE;
          end
        end
        default: state_q <= ST_STABLE;
      endcase
    end
  end

  assign w_sw_commit = committed_q;
`else
  localparam int unsigned c_unused_debounce = DEBOUNCE_CYCLES;

  assign w_sw_set    = (sync0_q != sync1_q);
  assign w_sw_commit = sync1_q;
`endif

  assign leds        = leds_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_io_switch_led_port.sv
`default_nettype none
// ============================================================================
// tb_io_switch_led_port : scoreboard bench for io_switch_led_port.   Rev 1.0
// ============================================================================
module tb_io_switch_led_port;

  localparam logic [31:0] c_LED    = 32'hFFFFFC60;
  localparam logic [31:0] c_SW     = 32'hFFFFFC70;
  localparam logic [31:0] c_STATUS = 32'hFFFFFC74;
  localparam logic [31:0] c_UNMAP  = 32'hFFFFFC80;
`ifdef IO_DEBOUNCE_EN
  localparam int c_LAT = 6;
`else
  localparam int c_LAT = 2;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        io_read;
  logic        io_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic [15:0] switches;
  logic [15:0] leds;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  io_switch_led_port #(
    .IO_BASE        (32'hFFFFFC00),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .io_read    (io_read),
    .io_write   (io_write),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .switches   (switches),
    .leds       (leds)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (rdata_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got rdata_valid=1 rdata=%h expected no response", rdata);
      end else begin
        check("rdata", rdata, exp_q.pop_front());
      end
    end
  end

  // Drivers are called at a negedge and return at the next negedge.
  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    io_read = 1'b1; io_write = 1'b0; addr = a;
    exp_q.push_back(e);
    @(negedge clock);
    io_read = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    io_write = 1'b1; io_read = 1'b0; addr = a; wdata = d;
    @(negedge clock);
    io_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; io_read = 1'b0; io_write = 1'b0;
    addr = 32'h0; wdata = 32'h0; switches = 16'h0;
    idle(3);
    reset = 1'b0;
    check("reset_leds", {16'h0, leds}, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_valid", {31'h0, rdata_valid}, 32'h0);

    rd(c_LED, 32'h0);
    rd(c_SW, 32'h0);
    rd(c_STATUS, 32'h0);
    idle(1);
    check("valid_single_pulse", {31'h0, rdata_valid}, 32'h0);

    wr(c_LED, 32'h0000A5A5);
    check("led_write", {16'h0, leds}, 32'h0000A5A5);
    rd(c_LED, 32'h0000A5A5);
    wr(c_SW, 32'h0000FFFF);
    wr(c_STATUS, 32'h00000001);
    check("led_after_ro_writes", {16'h0, leds}, 32'h0000A5A5);
    rd(c_UNMAP, 32'h0);
    idle(2);
    check("rdata_hold", rdata, 32'h0);

    // Read and write in one cycle: write lands, no response.
    io_read = 1'b1; io_write = 1'b1; addr = c_LED; wdata = 32'h00001234;
    idle(1);
    io_read = 1'b0; io_write = 1'b0;
    check("rw_valid", {31'h0, rdata_valid}, 32'h0);
    check("rw_leds", {16'h0, leds}, 32'h00001234);

    // Switch commit latency: read at edge j sees the value committed by edge j-1.
    switches = 16'h0003;
    for (int j = 1; j <= c_LAT + 1; j++)
      rd(c_SW, (j <= c_LAT) ? 32'h0 : 32'h3);
    rd(c_STATUS, 32'h1);
    rd(c_STATUS, 32'h0);

    // One-cycle glitch.
    switches = 16'h0083;
    idle(1);
    switches = 16'h0003;
    idle(c_LAT + 4);
    rd(c_SW, 32'h3);
`ifdef IO_DEBOUNCE_EN
    rd(c_STATUS, 32'h0);
`else
    rd(c_STATUS, 32'h1);
`endif
    rd(c_STATUS, 32'h0);

    // Commit coinciding with a STATUS read: set wins.
    switches = 16'h0007;
    idle(c_LAT - 1);
    rd(c_STATUS, 32'h0);
    rd(c_STATUS, 32'h1);
    rd(c_SW, 32'h7);
    rd(c_STATUS, 32'h0);

    // Reset in the middle of back-to-back reads.
    rd(c_LED, 32'h00001234);
    io_read = 1'b1; addr = c_LED; reset = 1'b1;
    idle(1);
    io_read = 1'b0; reset = 1'b0;
    check("reset_mid_valid", {31'h0, rdata_valid}, 32'h0);
    check("reset_mid_leds", {16'h0, leds}, 32'h0);
    check("reset_mid_rdata", rdata, 32'h0);

    idle(3);
    check("responses_outstanding", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
